// File: rtl/pokey_pot_scan_pkg.sv
// Shared definitions for the POKEY pot scan controller: FSM encoding and
// the terminal scan count used when a pot never crosses its threshold.
package pokey_pot_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_SCAN = 2'd2
  } pot_state_t;

  localparam int POT_MAX_COUNT = 228;

endpackage

// File: rtl/pokey_pot_scan_synchronizer.sv
// 3-flop synchronizer cell for one asynchronous comparator input.
// Output follows the input three rising clk edges later.
module synchronizer (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [2:0] sync_sr;

  // Shift the raw input through three flops; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_sr <= 3'b000;
    end else begin
      sync_sr <= {sync_sr[1:0], d};
    end
  end

  assign q = sync_sr[2];

endmodule

// File: rtl/pokey_pot_scan.sv
// POKEY paddle scan controller. Sequences capacitor dump and charge for up
// to NUM_POTS pots, counts scan ticks, and latches each pot's count when its
// synchronized comparator input reports the threshold was crossed.
//
// Strobe semantics: potgo, enable_15 and enable_179 are single-cycle strobes
// sampled on the rising clk edge; there is no backpressure. potgo outranks a
// tick arriving in the same cycle.
module pokey_pot_scan
  import pokey_pot_scan_pkg::*;
#(
  parameter int NUM_POTS  = 8,
  parameter int MAX_COUNT = POT_MAX_COUNT,
  parameter int CW        = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_15,
  input  logic                   enable_179,
  input  logic                   fast_mode,
  input  logic                   potgo,
  input  logic [NUM_POTS-1:0]    pot_in,
  output logic                   pot_dump,
  output logic [NUM_POTS-1:0]    allpot,
  output logic [NUM_POTS*CW-1:0] pot_value,
  output logic                   scan_active,
  output pot_state_t             state_dbg,
  output logic [CW-1:0]          count_dbg
);

  localparam logic [CW-1:0] MAX_CW = CW'(MAX_COUNT);

  pot_state_t          state;
  pot_state_t          state_next;
  logic [CW-1:0]       count;
  logic [NUM_POTS-1:0] allpot_q;
  logic [CW-1:0]       pot_value_q [NUM_POTS];
  logic [NUM_POTS-1:0] pot_sync;
  logic                tick;
  logic                start;
  logic                scan_tick;
  logic                terminal;

  // The tick source follows fast_mode combinationally each cycle.
  assign tick = fast_mode ? enable_179 : enable_15;

  for (genvar g = 0; g < NUM_POTS; g++) begin : g_sync
    synchronizer u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pot_in[g]),
      .q       (pot_sync[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath control strobes; potgo beats tick.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    scan_tick  = 1'b0;
    terminal   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (potgo) begin
          start      = 1'b1;
          state_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (potgo) begin
          start = 1'b1;
        end else if (tick) begin
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (potgo) begin
          start      = 1'b1;
          state_next = ST_DUMP;
        end else if (tick) begin
          scan_tick = 1'b1;
          if (count == MAX_CW) begin
            terminal   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter, allpot and result registers. On the terminal tick the counter
  // equals MAX_COUNT, so latching the counter there is the forced value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      allpot_q <= '0;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_value_q[i] <= '0;
      end
    end else if (start) begin
      count    <= '0;
      allpot_q <= {NUM_POTS{1'b1}};
    end else if (scan_tick) begin
      for (int i = 0; i < NUM_POTS; i++) begin
        if (allpot_q[i] && (terminal || pot_sync[i])) begin
          pot_value_q[i] <= count;
          allpot_q[i]    <= 1'b0;
        end
      end
      if (!terminal) begin
        count <= count + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_POTS; g++) begin : g_out
    assign pot_value[g*CW +: CW] = pot_value_q[g];
  end

  assign allpot      = allpot_q;
  assign pot_dump    = (state != ST_SCAN);
  assign scan_active = (state == ST_SCAN);
  assign state_dbg   = state;
  assign count_dbg   = count;

endmodule
